// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back L1 data cache.
package dcache_pkg;

    localparam int OFFSET_BITS = 5;
    localparam int INDEX_BITS  = 5;
    localparam int TAG_BITS    = 22;

    // Tag entry layout: {valid, dirty, tag}
    localparam int VALID_BIT = 23;
    localparam int DIRTY_BIT = 22;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        REFILL,
        REFILL_DONE
    } state_t;

endpackage

// File: rtl/dcache_sram.sv
// Single-port array: synchronous write, asynchronous read.
// clr_i clears the bits selected by CLR_MASK in every entry at once; it is used
// to drop valid/dirty on reset while leaving tags and data untouched.
module dcache_sram #(
    parameter int               WIDTH    = 24,
    parameter int               DEPTH    = 32,
    parameter logic [WIDTH-1:0] CLR_MASK = '0
) (
    input  logic                     clk_i,
    input  logic                     clr_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] memory [DEPTH];

    // Bulk clear takes priority over the normal write port
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) memory[i] <= memory[i] & ~CLR_MASK;
        end else if (we_i) begin
            memory[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = memory[addr_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Optional hit/miss/write-back counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256,
    parameter int TAG_BITS  = 22
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          p1_addr_i,
    input  logic [31:0]          p1_data_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic [31:0]          mem_addr_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o,
    output logic [31:0]          wb_cnt_o
`endif
);
    import dcache_pkg::*;

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int ENT_W  = TAG_BITS + 2;
    localparam int WSEL_W = $clog2(LINE_BITS / 32);
    localparam logic [ENT_W-1:0] VD_MASK = {2'b11, {TAG_BITS{1'b0}}};

    state_t state_q;

    logic [TAG_BITS-1:0]  a_tag;
    logic [IDX_W-1:0]     a_idx;
    logic [WSEL_W-1:0]    a_wsel;
    logic                 unused_addr;
    logic                 req, hit;
    logic [ENT_W-1:0]     tag_rd, tag_wd;
    logic [LINE_BITS-1:0] data_rd, data_wd, merged;
    logic                 tag_we, data_we;

    assign a_tag       = p1_addr_i[31 -: TAG_BITS];
    assign a_idx       = p1_addr_i[OFFSET_BITS +: IDX_W];
    assign a_wsel      = p1_addr_i[2 +: WSEL_W];
    assign unused_addr = ^p1_addr_i[1:0];

    assign req = p1_MemRead_i | p1_MemWrite_i;
    assign hit = tag_rd[VALID_BIT] && (tag_rd[TAG_BITS-1:0] == a_tag);

    // Any non-IDLE state stalls; in IDLE only an access that misses stalls
    assign p1_stall_o = (state_q != IDLE) || (req && !hit);
    assign p1_data_o  = p1_MemRead_i ? data_rd[a_wsel*32 +: 32] : 32'h0;

    // Store word merged into the currently indexed line
    always_comb begin
        merged = data_rd;
        merged[a_wsel*32 +: 32] = p1_data_i;
    end

    // Array write strobes: store hit in IDLE, or line fill on refill ack.
    // Reset masks both so an ack coincident with reset never lands.
    always_comb begin
        tag_we  = 1'b0;
        data_we = 1'b0;
        tag_wd  = '0;
        data_wd = '0;
        if (!rst_i) begin
            if (state_q == IDLE && req && hit && p1_MemWrite_i) begin
                tag_we  = 1'b1;
                data_we = 1'b1;
                tag_wd  = {1'b1, 1'b1, a_tag};
                data_wd = merged;
            end else if (state_q == REFILL && mem_ack_i) begin
                tag_we  = 1'b1;
                data_we = 1'b1;
                tag_wd  = {1'b1, 1'b0, a_tag};
                data_wd = mem_data_i;
            end
        end
    end

    dcache_sram #(.WIDTH(ENT_W), .DEPTH(NUM_LINES), .CLR_MASK(VD_MASK)) dcache_tag_sram (
        .clk_i   (clk_i),
        .clr_i   (rst_i),
        .we_i    (tag_we),
        .addr_i  (a_idx),
        .wdata_i (tag_wd),
        .rdata_o (tag_rd)
    );

    dcache_sram #(.WIDTH(LINE_BITS), .DEPTH(NUM_LINES)) dcache_data_sram (
        .clk_i   (clk_i),
        .clr_i   (1'b0),
        .we_i    (data_we),
        .addr_i  (a_idx),
        .wdata_i (data_wd),
        .rdata_o (data_rd)
    );

    // Miss-handling FSM with registered memory-side outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && !hit) state_q <= MISS;
                end
                MISS: begin
                    mem_enable_o <= 1'b1;
                    if (tag_rd[VALID_BIT] && tag_rd[DIRTY_BIT]) begin
                        state_q     <= WRITEBACK;
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= {tag_rd[TAG_BITS-1:0], a_idx, {OFFSET_BITS{1'b0}}};
                        mem_data_o  <= data_rd;
                    end else begin
                        state_q     <= REFILL;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {a_tag, a_idx, {OFFSET_BITS{1'b0}}};
                    end
                end
                WRITEBACK: begin
                    // Enable stays high straight into the refill request
                    if (mem_ack_i) begin
                        state_q     <= REFILL;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {a_tag, a_idx, {OFFSET_BITS{1'b0}}};
                        mem_data_o  <= '0;
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        state_q      <= REFILL_DONE;
                        mem_enable_o <= 1'b0;
                        mem_addr_o   <= '0;
                    end
                end
                REFILL_DONE: state_q <= IDLE;
                default:     state_q <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // replay_q marks the IDLE cycle that completes an access after a refill,
    // so that completion is not also counted as a hit
    logic replay_q;

    // Saturating event counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            replay_q   <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            wb_cnt_o   <= '0;
        end else begin
            replay_q <= (state_q == REFILL_DONE);
            if (state_q == IDLE && req && hit && !replay_q && hit_cnt_o != '1)
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (state_q == IDLE && req && !hit && miss_cnt_o != '1)
                miss_cnt_o <= miss_cnt_o + 32'd1;
            if (state_q == WRITEBACK && mem_ack_i && wb_cnt_o != '1)
                wb_cnt_o <= wb_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller.
- Sits between the CPU MEM stage (p1 side) and the 256-bit line-based Data_Memory (mem side).
- Stalls the pipeline on a miss, writes back the dirty victim, refills the line, then completes the access.
- Holds its own tag and data arrays so the bench can preload and flush them by hierarchy.

Parameters:
- NUM_LINES, 32, number of cache lines (index width = log2).
- LINE_BITS, 256, line width in bits (32 bytes, 8 words).
- TAG_BITS, 22, address tag width; a stored tag entry is TAG_BITS+2 bits = {valid, dirty, tag}.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- p1_addr_i  in  32  byte address from MEM stage
- p1_data_i  in  32  store data
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request
- p1_data_o  out  32  load data
- p1_stall_o  out  1  stall pipeline
- mem_data_i  in  256  refill line from memory
- mem_ack_i  in  1  memory done (1-cycle pulse)
- mem_data_o  out  256  write-back line
- mem_addr_o  out  32  line address, low 5 bits zero
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1 = write-back, 0 = refill read

Behaviour:
- Address split: offset = addr[4:0]; word select = addr[4:2]; index = addr[9:5]; tag = addr[31:10].
- Arrays: tag array NUM_LINES x 24 = {valid[23], dirty[22], tag[21:0]}; data array NUM_LINES x 256.
- Both arrays are named memory, inside instances dcache_tag_sram and dcache_data_sram.
- hit = valid && stored tag == addr tag.
- req = MemRead | MemWrite. If both are high, the access is treated as a write.
- Stall: p1_stall_o = req && !hit, combinational. It is asserted in every non-IDLE state.
- p1_data_o = selected word of the indexed line whenever MemRead; otherwise 0.
- States:
  - IDLE: on req && hit with write, at the posedge write the word into the line and set dirty=1. No stall on hits.
  - IDLE to MISS: taken at the posedge on req && !hit.
  - MISS: if victim valid && dirty, go to WRITEBACK; else go to REFILL.
  - WRITEBACK: drive mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line.
    - Hold these levels until mem_ack_i, then go to REFILL.
  - REFILL: drive mem_enable_o=1, mem_write_o=0, mem_addr_o={addr tag, index, 5'b0}.
    - On mem_ack_i, write mem_data_i into the line and set the tag entry to {1, 0, tag}; go to REFILL_DONE.
  - REFILL_DONE: one cycle, no memory request; go to IDLE.
    - In IDLE the access now hits: a load returns data and the stall drops; a store merges and sets dirty in that IDLE cycle.
- mem_enable_o is a level, not a pulse. It deasserts in the cycle after ack is sampled.
- The p1 inputs must stay stable while stalled. The controller does not latch them.
- Reset (rst_i=1 at a posedge), including mid-miss:
  - state to IDLE; mem_enable_o, mem_write_o, mem_addr_o, mem_data_o all 0.
  - valid and dirty cleared for all lines; tags and data unchanged.
  - An in-flight refill is discarded and the line stays unmodified.
- An ack arriving outside WRITEBACK or REFILL is ignored.
- Zero-latency memory is legal: ack in the same cycle as the first enable still completes the transfer.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined: adds 32-bit outputs hit_cnt_o and miss_cnt_o, plus wb_cnt_o.
  - hit_cnt_o increments once per access completed without entering MISS.
  - miss_cnt_o increments on each IDLE to MISS transition.
  - wb_cnt_o increments on each WRITEBACK ack.
  - All three are cleared by rst_i and saturate at 2^32-1.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE};
  - OFFSET_BITS=5, INDEX_BITS=5, TAG_BITS=22;
  - bit positions VALID_BIT=23, DIRTY_BIT=22.
- One sub-module, dcache_sram: single-port synchronous-write, asynchronous-read array.
  - Parameterised width and depth, with array named memory.
  - Instantiated twice, as dcache_tag_sram and dcache_data_sram.

Test Plan:
- Cold read: reset, Data_Memory line 0 = 256'h5, load 0x00.
  - stall=1 during refill; no write-back; mem_addr 0x00; then p1_data_o=32'h5 and stall=0.
- Write hit: after the line above, store 0x04 = 32'hDEAD.
  - No stall; line 0 word1 = DEAD; dirty=1; mem_enable_o stays 0.
- Dirty eviction: store 0x400 (same index 0, tag 1).
  - WRITEBACK to addr 0x00 with data word1=DEAD, word0=5.
  - Then REFILL from 0x400; tag entry = {1,1,22'h1} after the store merges.
- Read miss, clean victim: load 0x20 with line 1 invalid.
  - No write cycle; single refill from 0x20; stall length = memory latency + 3.
- Reset mid-REFILL: assert rst_i while mem_enable_o=1.
  - Next cycle mem_enable_o=0, state IDLE, all valid bits 0; the late ack is ignored.
- DCACHE_STATS_EN build: run the sequence above (excluding reset).
  - Expect hit_cnt_o=1, miss_cnt_o=3, wb_cnt_o=1.
